// File: rtl/mul_issue_ctrl.sv
// Issue controller for a multi-cycle multiplier: accepts one op from decode, pulses start,
// waits for the unit's valid and hands the result to writeback, with flush and timeout handling.
module mul_issue_ctrl #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic             id_op,
  input  logic [31:0]      id_a,
  input  logic [31:0]      id_b,
  input  logic [TAG_W-1:0] id_rd,
  input  logic             flush,
  output logic             mul_start,
  output logic             mul_op,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic             mul_valid,
  input  logic [31:0]      mul_result,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  input  logic             wb_ready,
  output logic             stall,
  output logic             err_timeout
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DRAIN} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               op_q;
  logic [31:0]        a_q, b_q, data_q;
  logic [TAG_W-1:0]   rd_q;
  logic               accept, capture;

  assign id_ready    = (state_q == IDLE) && !flush;
  assign stall       = id_valid && !id_ready;
  assign accept      = id_valid && id_ready;
  assign mul_start   = (state_q == ISSUE);
  assign wb_valid    = (state_q == HOLD);
  assign mul_op      = op_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign wb_rd       = rd_q;
  assign wb_data     = data_q;
  assign err_timeout = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      // The unit is committed once start fires, so a flush here must still drain it.
      ISSUE: begin
        cnt_d   = '0;
        state_d = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mul_valid) begin
          capture = !flush;
          state_d = flush ? IDLE : HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      HOLD:  if (flush || wb_ready) state_d = IDLE;
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (mul_valid) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        op_q <= id_op;
        a_q  <= id_a;
        b_q  <= id_b;
        rd_q <= id_rd;
      end
      if (capture) data_q <= mul_result;
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl; the multiplier side is driven cycle by cycle from each task.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready, id_op;
  logic [31:0] id_a, id_b;
  logic [4:0]  id_rd;
  logic        flush, mul_start, mul_op;
  logic [31:0] mul_a, mul_b;
  logic        mul_valid;
  logic [31:0] mul_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready, stall, err_timeout;

  int checks = 0;
  int errors = 0;

  mul_issue_ctrl #(.TAG_W(5), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
    .id_a(id_a), .id_b(id_b), .id_rd(id_rd), .flush(flush),
    .mul_start(mul_start), .mul_op(mul_op), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid(mul_valid), .mul_result(mul_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .stall(stall), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 more unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Presents an op and steps into ISSUE.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    id_valid = 1'b1; id_op = 1'b1; id_a = a; id_b = b; id_rd = rd;
    tick();
    id_valid = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_valid = 0; id_op = 0; id_a = 0; id_b = 0; id_rd = 0; flush = 0;
    mul_valid = 0; mul_result = 0; wb_ready = 0;
    tick(); tick();
    rst = 1'b0;
    settle();
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready: got %b exp 1", id_ready); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b exp 0", mul_start); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b exp 0", wb_valid); end
    checks++; if ({mul_a, mul_b, wb_data} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h %h %h exp 0", mul_a, mul_b, wb_data); end
    checks++; if ({wb_rd, mul_op, err_timeout} !== 7'h0) begin errors++; $display("FAIL reset_misc: got %h %b %b exp 0", wb_rd, mul_op, err_timeout); end
  endtask

  task automatic test_basic();
    int starts = 0;
    issue(32'd7, 32'd6, 5'd3);
    if (mul_start === 1'b1) starts++;
    checks++; if (mul_a !== 32'd7 || mul_b !== 32'd6 || mul_op !== 1'b1) begin errors++; $display("FAIL basic_operands: got %0d %0d %b exp 7 6 1", mul_a, mul_b, mul_op); end
    for (int i = 0; i < 9; i++) begin
      tick();
      if (mul_start === 1'b1) starts++;
    end
    tick();
    mul_valid = 1'b1; mul_result = 32'd42;
    settle();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL basic_wb_early: got %b exp 0", wb_valid); end
    tick();
    mul_valid = 1'b0; mul_result = 32'hDEADBEEF; wb_ready = 1'b1;
    settle();
    checks++; if (starts !== 1) begin errors++; $display("FAIL basic_start_count: got %0d exp 1", starts); end
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd42 || wb_rd !== 5'd3) begin errors++; $display("FAIL basic_wb: got v=%b d=%0d rd=%0d exp 1 42 3", wb_valid, wb_data, wb_rd); end
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b exp 0", id_ready); end
    tick();
    wb_ready = 1'b0;
    settle();
    checks++; if (id_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL basic_done: got rdy=%b v=%b exp 1 0", id_ready, wb_valid); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    issue(32'd3, 32'd5, 5'd9);
    id_valid = 1'b1; id_a = 32'd100; id_b = 32'd4; id_rd = 5'd17;
    settle();
    checks++; if (stall !== 1'b1 || mul_start !== 1'b1) begin errors++; $display("FAIL b2b_issue: got stall=%b start=%b exp 1 1", stall, mul_start); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stall !== 1'b1 || mul_start !== 1'b0) bad++;
    end
    mul_valid = 1'b1; mul_result = 32'd15;
    tick();
    mul_valid = 1'b0; mul_result = 32'd0;
    settle();
    for (int i = 0; i < 5; i++) begin
      if (wb_valid !== 1'b1 || wb_data !== 32'd15 || wb_rd !== 5'd9 || stall !== 1'b1 || mul_start !== 1'b0 || mul_a !== 32'd3) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_hold: got %0d bad cycles exp 0", bad); end
    wb_ready = 1'b1;
    settle();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd15) begin errors++; $display("FAIL b2b_hold_end: got v=%b d=%0d exp 1 15", wb_valid, wb_data); end
    tick();
    wb_ready = 1'b0;
    settle();
    checks++; if (id_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_reaccept: got rdy=%b stall=%b exp 1 0", id_ready, stall); end
    tick();
    id_valid = 1'b0;
    settle();
    checks++; if (mul_start !== 1'b1 || mul_a !== 32'd100 || mul_b !== 32'd4) begin errors++; $display("FAIL b2b_second: got start=%b a=%0d b=%0d exp 1 100 4", mul_start, mul_a, mul_b); end
    tick();
    mul_valid = 1'b1; mul_result = 32'd400;
    tick();
    mul_valid = 1'b0; wb_ready = 1'b1;
    settle();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd400 || wb_rd !== 5'd17) begin errors++; $display("FAIL b2b_second_wb: got v=%b d=%0d rd=%0d exp 1 400 17", wb_valid, wb_data, wb_rd); end
    tick();
    wb_ready = 1'b0;
    settle();
  endtask

  task automatic test_flush_wait();
    int bad = 0;
    issue(32'd2, 32'd8, 5'd1);
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    settle();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flushw_ready: got %b exp 0", id_ready); end
    tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (wb_valid !== 1'b0 || id_ready !== 1'b0 || mul_a !== 32'd2) bad++;
      tick();
    end
    mul_valid = 1'b1; mul_result = 32'd16;
    settle();
    checks++; if (bad !== 0 || id_ready !== 1'b0) begin errors++; $display("FAIL flushw_drain: got %0d bad rdy=%b exp 0 0", bad, id_ready); end
    tick();
    mul_valid = 1'b0;
    settle();
    checks++; if (id_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL flushw_done: got rdy=%b v=%b exp 1 0", id_ready, wb_valid); end
    // flush coincident with mul_valid returns straight to IDLE
    issue(32'd4, 32'd4, 5'd2);
    tick(); tick();
    mul_valid = 1'b1; mul_result = 32'd16; flush = 1'b1;
    tick();
    mul_valid = 1'b0; flush = 1'b0;
    settle();
    checks++; if (id_ready !== 1'b1 || wb_valid !== 1'b0 || wb_data !== 32'd400) begin errors++; $display("FAIL flush_same: got rdy=%b v=%b d=%0d exp 1 0 400", id_ready, wb_valid, wb_data); end
  endtask

  task automatic test_flush_issue();
    issue(32'd9, 32'd9, 5'd4);
    flush = 1'b1;
    settle();
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL flushi_start: got %b exp 1", mul_start); end
    tick();
    flush = 1'b0;
    settle();
    checks++; if (mul_start !== 1'b0 || wb_valid !== 1'b0 || id_ready !== 1'b0) begin errors++; $display("FAIL flushi_drain: got s=%b v=%b rdy=%b exp 0 0 0", mul_start, wb_valid, id_ready); end
    tick(); tick();
    mul_valid = 1'b1; mul_result = 32'd81;
    tick();
    mul_valid = 1'b0;
    settle();
    checks++; if (id_ready !== 1'b1 || wb_valid !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL flushi_done: got rdy=%b v=%b err=%b exp 1 0 0", id_ready, wb_valid, err_timeout); end
  endtask

  task automatic test_timeout();
    int bad = 0;
    issue(32'd1, 32'd1, 5'd5);
    tick();
    for (int i = 0; i < 15; i++) begin
      if (err_timeout !== 1'b0 || id_ready !== 1'b0 || wb_valid !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL timeout_early: got %0d bad cycles exp 0", bad); end
    checks++; if (err_timeout !== 1'b1 || id_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got err=%b rdy=%b v=%b exp 1 1 0", err_timeout, id_ready, wb_valid); end
    tick();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b exp 0", err_timeout); end
  endtask

  task automatic test_async_reset();
    issue(32'd5, 32'd6, 5'd7);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin errors++; $display("FAIL areset_data: got %h %h %h %h exp 0", mul_a, mul_b, wb_data, wb_rd); end
    checks++; if (id_ready !== 1'b1 || wb_valid !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL areset_ctrl: got rdy=%b v=%b s=%b exp 1 0 0", id_ready, wb_valid, mul_start); end
    tick();
    rst = 1'b0;
    settle();
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL areset_release: got %b exp 1", id_ready); end
    issue(32'hFFFFFFFF, 32'd2, 5'd31);
    checks++; if (mul_start !== 1'b1 || mul_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL areset_issue: got s=%b a=%h exp 1 ffffffff", mul_start, mul_a); end
    tick(); tick();
    mul_valid = 1'b1; mul_result = 32'hFFFFFFFE;
    tick();
    mul_valid = 1'b0; wb_ready = 1'b1;
    settle();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFFFFFE || wb_rd !== 5'd31) begin errors++; $display("FAIL areset_wb: got v=%b d=%h rd=%0d exp 1 fffffffe 31", wb_valid, wb_data, wb_rd); end
    tick();
    wb_ready = 1'b0;
    settle();
    checks++; if (id_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL areset_done: got rdy=%b v=%b exp 1 0", id_ready, wb_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush_wait();
    test_flush_issue();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
